// File: rtl/game_state_sequencer.sv
// rtl/game_state_sequencer.sv - StickmanRun game flow controller
// Owns level select, countdown, play/pause, win/lose screens and the shared frame counter.
module game_state_sequencer #(
  parameter int         WAIT_FRAMES   = 90,
  parameter int         LEVEL1_FRAMES = 1800,
  parameter int         LEVEL2_FRAMES = 2400,
  parameter logic [7:0] KEY_ENTER     = 8'h28,
  parameter logic [7:0] KEY_SPACE     = 8'h2C,
  parameter logic [7:0] KEY_1         = 8'h1E,
  parameter logic [7:0] KEY_2         = 8'h1F,
  parameter logic [7:0] KEY_P         = 8'h13,
  parameter logic [7:0] KEY_R         = 8'h15
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  keycode,
  input  logic        frame_clk,
  input  logic        lose_evt,
  input  logic        coin_evt,
  output logic [4:0]  status,
  output logic [1:0]  level_status,
  output logic [11:0] frame_counter,
  output logic [3:0]  coin_count,
  output logic        frame_tick,
  output logic        paused,
  output logic        restart
);

  typedef enum logic [2:0] {
    S_SELECT,
    S_WAIT,
    S_PLAY,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [11:0] WAIT_LOAD = 12'(WAIT_FRAMES);
  localparam logic [11:0] L1_TARGET = 12'(LEVEL1_FRAMES);
  localparam logic [11:0] L2_TARGET = 12'(LEVEL2_FRAMES);

  state_t      state;
  logic [11:0] countdown;
  logic        vs_s1, vs_s2, vs_s3;
  logic [7:0]  key_q, key_q2;

  logic        key_new;
  logic        p_enter, p_space, p_1, p_2, p_p, p_r;
  logic [11:0] fc_inc;
  logic [3:0]  cc_inc;
  logic [11:0] target;

  // A press is the first cycle a keycode is seen, so held keys act once.
  assign key_new = (key_q != key_q2);
  assign p_enter = key_new && (key_q == KEY_ENTER);
  assign p_space = key_new && (key_q == KEY_SPACE);
  assign p_1     = key_new && (key_q == KEY_1);
  assign p_2     = key_new && (key_q == KEY_2);
  assign p_p     = key_new && (key_q == KEY_P);
  assign p_r     = key_new && (key_q == KEY_R);

  assign fc_inc  = (frame_counter == 12'hFFF) ? frame_counter : frame_counter + 12'd1;
  assign cc_inc  = (coin_count == 4'hF) ? coin_count : coin_count + 4'd1;
  assign target  = level_status[1] ? L2_TARGET : L1_TARGET;
  assign restart = status[3];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state         <= S_SELECT;
      status        <= 5'b10000;
      level_status  <= 2'b01;
      frame_counter <= 12'd0;
      coin_count    <= 4'd0;
      frame_tick    <= 1'b0;
      paused        <= 1'b0;
      countdown     <= 12'd0;
      vs_s1         <= 1'b0;
      vs_s2         <= 1'b0;
      vs_s3         <= 1'b0;
      key_q         <= 8'd0;
      key_q2        <= 8'd0;
    end else begin
      vs_s1      <= frame_clk;
      vs_s2      <= vs_s1;
      vs_s3      <= vs_s2;
      frame_tick <= vs_s2 & ~vs_s3;
      key_q      <= keycode;
      key_q2     <= key_q;

      case (state)
        S_SELECT: begin
          paused <= 1'b0;
          if (p_1) begin
            level_status <= 2'b01;
          end else if (p_2) begin
            level_status <= 2'b10;
          end else if (p_enter) begin
            state         <= S_WAIT;
            status        <= 5'b01000;
            countdown     <= WAIT_LOAD;
            frame_counter <= 12'd0;
            coin_count    <= 4'd0;
          end
        end

        S_WAIT: begin
          paused        <= 1'b0;
          frame_counter <= 12'd0;
          if (p_space) begin
            state  <= S_PLAY;
            status <= 5'b00100;
          end else if (frame_tick) begin
            // countdown of 0 or 1 both end on this tick
            if (countdown <= 12'd1) begin
              state     <= S_PLAY;
              status    <= 5'b00100;
              countdown <= 12'd0;
            end else begin
              countdown <= countdown - 12'd1;
            end
          end
        end

        S_PLAY: begin
          if (paused) begin
            if (p_p) begin
              paused <= 1'b0;
            end else if (p_enter) begin
              state  <= S_SELECT;
              status <= 5'b10000;
              paused <= 1'b0;
            end
          end else if (lose_evt) begin
            state  <= S_LOSE;
            status <= 5'b00001;
          end else begin
            if (coin_evt)
              coin_count <= cc_inc;
            if (frame_tick)
              frame_counter <= fc_inc;
            if (frame_tick && (fc_inc == target)) begin
              state  <= S_WIN;
              status <= 5'b00010;
            end else if (p_p) begin
              paused <= 1'b1;
            end
          end
        end

        S_WIN, S_LOSE: begin
          paused <= 1'b0;
          if (p_r) begin
            state         <= S_WAIT;
            status        <= 5'b01000;
            countdown     <= WAIT_LOAD;
            frame_counter <= 12'd0;
            coin_count    <= 4'd0;
          end else if (p_enter) begin
            state  <= S_SELECT;
            status <= 5'b10000;
          end
        end

        default: begin
          state  <= S_SELECT;
          status <= 5'b10000;
          paused <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_sequencer.sv
// tb/tb_game_state_sequencer.sv - directed scoreboard bench for game_state_sequencer
module tb_game_state_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [7:0]  keycode = 8'd0;
  logic        frame_clk = 1'b0;
  logic        lose_evt = 1'b0;
  logic        coin_evt = 1'b0;
  logic [4:0]  status;
  logic [1:0]  level_status;
  logic [11:0] frame_counter;
  logic [3:0]  coin_count;
  logic        frame_tick;
  logic        paused;
  logic        restart;

  localparam logic [7:0] K_ENTER = 8'h28;
  localparam logic [7:0] K_SPACE = 8'h2C;
  localparam logic [7:0] K_1     = 8'h1E;
  localparam logic [7:0] K_2     = 8'h1F;
  localparam logic [7:0] K_P     = 8'h13;
  localparam logic [7:0] K_R     = 8'h15;

  game_state_sequencer #(
    .WAIT_FRAMES  (3),
    .LEVEL1_FRAMES(5),
    .LEVEL2_FRAMES(40)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .keycode      (keycode),
    .frame_clk    (frame_clk),
    .lose_evt     (lose_evt),
    .coin_evt     (coin_evt),
    .status       (status),
    .level_status (level_status),
    .frame_counter(frame_counter),
    .coin_count   (coin_count),
    .frame_tick   (frame_tick),
    .paused       (paused),
    .restart      (restart)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic expect_v(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check_v(input logic [15:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    cycles(2);
    keycode = 8'd0;
    cycles(2);
  endtask

  // One VGA_VS pulse; coin/lose are driven in the cycle frame_tick is high.
  task automatic frame(input bit coin, input bit lose, input bit chk_tick);
    frame_clk = 1'b1;
    cycles(2);
    if (chk_tick) begin
      expect_v("tick_not_yet", 16'd0);
      check_v(16'(frame_tick));
    end
    cycles(1);
    if (chk_tick) begin
      expect_v("tick_high", 16'd1);
      check_v(16'(frame_tick));
    end
    coin_evt = coin;
    lose_evt = lose;
    cycles(1);
    coin_evt  = 1'b0;
    lose_evt  = 1'b0;
    frame_clk = 1'b0;
    if (chk_tick) begin
      expect_v("tick_one_cycle", 16'd0);
      check_v(16'(frame_tick));
    end
    cycles(2);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset state
    cycles(3);
    expect_v("rst_status", 16'b10000);  check_v(16'(status));
    expect_v("rst_level", 16'b01);      check_v(16'(level_status));
    expect_v("rst_fc", 16'd0);          check_v(16'(frame_counter));
    expect_v("rst_cc", 16'd0);          check_v(16'(coin_count));
    expect_v("rst_paused", 16'd0);      check_v(16'(paused));
    expect_v("rst_tick", 16'd0);        check_v(16'(frame_tick));
    Reset_n = 1'b1;
    cycles(1);

    // select level 2 and enter
    press(K_2);
    expect_v("sel_lvl2", 16'b10);       check_v(16'(level_status));
    keycode = K_ENTER;
    cycles(2);
    expect_v("enter_wait", 16'b01000);  check_v(16'(status));
    expect_v("restart_wait", 16'd1);    check_v(16'(restart));
    expect_v("wait_fc", 16'd0);         check_v(16'(frame_counter));
    keycode = 8'd0;
    cycles(2);

    // countdown of 3 frames
    frame(1'b0, 1'b0, 1'b1);
    frames(1);
    expect_v("cd_still_wait", 16'b01000); check_v(16'(status));
    frames(1);
    expect_v("cd_play", 16'b00100);     check_v(16'(status));
    expect_v("cd_fc", 16'd0);           check_v(16'(frame_counter));

    // pause then back to select
    press(K_P);
    expect_v("pause_on", 16'd1);        check_v(16'(paused));
    press(K_ENTER);
    expect_v("pause_select", 16'b10000); check_v(16'(status));
    expect_v("pause_sel_lvl", 16'b10);  check_v(16'(level_status));

    // level 1, skip countdown with held space
    press(K_1);
    press(K_ENTER);
    keycode = K_SPACE;
    cycles(20);
    keycode = 8'd0;
    cycles(1);
    expect_v("space_play", 16'b00100);  check_v(16'(status));
    expect_v("space_fc", 16'd0);        check_v(16'(frame_counter));
    expect_v("space_paused", 16'd0);    check_v(16'(paused));

    // win at 5 frames, coin and tick in the same cycle
    frames(1);
    frame(1'b1, 1'b0, 1'b0);
    frames(2);
    expect_v("pre_win_fc", 16'd4);      check_v(16'(frame_counter));
    expect_v("pre_win_cc", 16'd1);      check_v(16'(coin_count));
    expect_v("pre_win_st", 16'b00100);  check_v(16'(status));
    frames(1);
    expect_v("win_status", 16'b00010);  check_v(16'(status));
    expect_v("win_fc", 16'd5);          check_v(16'(frame_counter));
    frames(2);
    coin_evt = 1'b1;
    cycles(1);
    coin_evt = 1'b0;
    cycles(1);
    expect_v("win_fc_frozen", 16'd5);   check_v(16'(frame_counter));
    expect_v("win_cc_frozen", 16'd1);   check_v(16'(coin_count));

    // back to select, level kept
    press(K_ENTER);
    expect_v("win_select", 16'b10000);  check_v(16'(status));
    expect_v("win_sel_lvl", 16'b01);    check_v(16'(level_status));

    // lose on the same tick as the win target
    press(K_ENTER);
    press(K_SPACE);
    frames(1);
    frame(1'b1, 1'b0, 1'b0);
    frames(2);
    frame(1'b0, 1'b1, 1'b0);
    expect_v("lose_beats_win", 16'b00001); check_v(16'(status));
    press(K_R);
    expect_v("retry_wait", 16'b01000);  check_v(16'(status));
    expect_v("retry_lvl", 16'b01);      check_v(16'(level_status));
    expect_v("retry_cc", 16'd0);        check_v(16'(coin_count));
    expect_v("retry_fc", 16'd0);        check_v(16'(frame_counter));

    // pause freezes counters and ignores events
    press(K_SPACE);
    frames(2);
    expect_v("pp_fc", 16'd2);           check_v(16'(frame_counter));
    press(K_P);
    expect_v("pp_paused", 16'd1);       check_v(16'(paused));
    for (int i = 0; i < 10; i++) frame(i < 3, i == 5, 1'b0);
    expect_v("pp_fc_frozen", 16'd2);    check_v(16'(frame_counter));
    expect_v("pp_cc_frozen", 16'd0);    check_v(16'(coin_count));
    expect_v("pp_status", 16'b00100);   check_v(16'(status));
    press(K_P);
    expect_v("pp_resumed", 16'd0);      check_v(16'(paused));
    frames(1);
    expect_v("pp_fc_resume", 16'd3);    check_v(16'(frame_counter));
    for (int i = 0; i < 16; i++) begin
      coin_evt = 1'b1;
      cycles(1);
      coin_evt = 1'b0;
      cycles(1);
    end
    expect_v("cc_saturate", 16'd15);    check_v(16'(coin_count));

    // reset mid-play while paused
    press(K_P);
    press(K_ENTER);
    press(K_2);
    press(K_ENTER);
    press(K_SPACE);
    frames(37);
    expect_v("mid_fc", 16'd37);         check_v(16'(frame_counter));
    press(K_P);
    expect_v("mid_paused", 16'd1);      check_v(16'(paused));
    Reset_n = 1'b0;
    cycles(1);
    Reset_n = 1'b1;
    expect_v("mr_status", 16'b10000);   check_v(16'(status));
    expect_v("mr_level", 16'b01);       check_v(16'(level_status));
    expect_v("mr_fc", 16'd0);           check_v(16'(frame_counter));
    expect_v("mr_paused", 16'd0);       check_v(16'(paused));
    expect_v("mr_cc", 16'd0);           check_v(16'(coin_count));
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_sequencer.md
Name: game_state_sequencer

Overview:
- Top-level game flow controller for the StickmanRun design.
- Sequences the whole game: level select, pre-run countdown, play, pause, and the win and lose screens.
- Owns the shared frame_counter that drives scrolling, score and sprites, and publishes the one-hot status vector and level_status consumed by the renderers and color_mapper.
- Inputs are the NIOS keycode, VGA_VS as frame reference, and event pulses from the collision logic.

Parameters:
- WAIT_FRAMES, 90: frames of countdown in WAIT before PLAY.
- LEVEL1_FRAMES, 1800: play frames needed to win level 1.
- LEVEL2_FRAMES, 2400: play frames needed to win level 2.
- KEY_ENTER, 8'h28: confirm key.
- KEY_SPACE, 8'h2C: skip countdown.
- KEY_1, 8'h1E: select level 1.
- KEY_2, 8'h1F: select level 2.
- KEY_P, 8'h13: pause toggle.
- KEY_R, 8'h15: retry.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset_n  in  1  synchronous, active-low reset.
- keycode  in  8  current USB HID keycode; 0 = none.
- frame_clk  in  1  VGA_VS; asynchronous to Clk.
- lose_evt  in  1  one-Clk pulse: stickman hit an obstacle or fell.
- coin_evt  in  1  one-Clk pulse: coin collected.
- status  out  5  one-hot {selecting, waiting, playing, win, lose}.
- level_status  out  2  01 = level 1, 10 = level 2.
- frame_counter  out  12  play-time frame count.
- coin_count  out  4  coins this run.
- frame_tick  out  1  one-Clk pulse per frame.
- paused  out  1  high while PLAY is paused.
- restart  out  1  equals status[3]; renderers reset positions while high.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-low (Reset_n), sampled on the Clk rising edge.
- Reset values: state SELECT, status 5'b10000, level_status 2'b01, frame_counter 0, coin_count 0, frame_tick 0, paused 0, countdown 0, all sync and edge flops 0.
- frame_clk handling: pass through a 2-flop synchronizer, then detect the rising edge. frame_tick is registered and asserts 3 Clk cycles after the VGA_VS rising edge, for exactly 1 cycle.
- Key detection:
  - key_q <= keycode; key_q2 <= key_q.
  - press(K) = (key_q == K) && (key_q2 != K).
  - Held keys act once. The state update lands 2 Clk edges after keycode changes.
- SELECT:
  - press KEY_1 → level_status 01; press KEY_2 → level_status 10.
  - press KEY_ENTER → WAIT; countdown loads WAIT_FRAMES, frame_counter 0, coin_count 0.
  - Other keys are ignored.
- WAIT:
  - frame_counter held at 0.
  - countdown decrements on frame_tick; the tick that finds countdown == 1 → PLAY.
  - press KEY_SPACE → PLAY immediately.
  - WAIT_FRAMES == 0 → PLAY on the first frame_tick.
- PLAY, not paused:
  - frame_counter += 1 on frame_tick, saturating at 4095.
  - coin_evt → coin_count += 1, saturating at 15.
  - lose_evt → LOSE.
  - frame_counter reaching target (LEVEL1_FRAMES or LEVEL2_FRAMES per level_status) → WIN, on the same edge the counter reaches target.
  - press KEY_P → paused = 1.
- PLAY, paused:
  - status stays 00100; frame_counter frozen; coin_evt and lose_evt ignored.
  - press KEY_P → paused = 0.
  - press KEY_ENTER → SELECT.
- WIN and LOSE:
  - frame_counter and coin_count frozen.
  - press KEY_R → WAIT with the same level, countdown reloaded, frame_counter 0, coin_count 0.
  - press KEY_ENTER → SELECT; level_status is kept.
- Priorities within one Clk cycle:
  - Reset beats everything.
  - In PLAY, lose_evt beats win-on-target (the lose wins).
  - frame_tick and coin_evt in the same cycle: both counters update.
  - A key press and frame_tick in the same cycle: the key-driven transition wins; counter updates from that tick are dropped if the state leaves PLAY or WAIT.
  - lose_evt in the same cycle as press KEY_P → LOSE.
- Reset mid-operation (any state, any paused value): next edge returns to SELECT with all reset values.
- Output integrity: status is always exactly one-hot. Illegal encodings recover to SELECT. paused is forced to 0 outside PLAY.

Test Plan:
- Reset, select level 2, enter: release Reset_n; keycode 1F, then 00, then 28 → level_status 10, status 01000 two cycles after 28, frame_counter 0.
- Countdown: with WAIT_FRAMES=3, drive 3 VGA_VS edges → status 00100 on the edge following the 3rd frame_tick; frame_counter 0. Repeat with keycode 2C held for 20 cycles → PLAY once; no other effect.
- Win: level 1, LEVEL1_FRAMES=5 → after 5 ticks status 00010, frame_counter 5; further ticks leave it at 5.
- Lose versus win: drive lose_evt on the same cycle as the 5th tick → status 00001. In LOSE, press 15 → WAIT, level unchanged, coin_count 0.
- Pause: in PLAY, press 13 → paused 1. 10 ticks and 3 coin_evt → frame_counter and coin_count unchanged. Press 13 → counting resumes. 16 coin_evt → coin_count saturates at 15.
- Reset mid-PLAY: frame_counter 37, paused 1, Reset_n low 1 cycle → status 10000, level_status 01, frame_counter 0, paused 0.
